// File: rtl/gam_learning_insert_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gam_learning_insert_if
// Purpose  : Bundles the GAM learning request, result and recall-read signals.
//            Master = requester/recall side, slave = learning stage.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface gam_learning_insert_if #(
   parameter int DIM         = 8,
   parameter int ELEM_W      = 8,
   parameter int CLASS_COUNT = 4,
   parameter int NODE_COUNT  = 16
);
   localparam int c_CLS_W  = $clog2(CLASS_COUNT);
   localparam int c_NODE_W = $clog2(NODE_COUNT);
   localparam int c_DIST_W = 2*ELEM_W + $clog2(DIM);
   localparam int c_VEC_W  = DIM*ELEM_W;

   logic                in_valid;
   logic                in_ready;
   logic [c_VEC_W-1:0]  in_x;
   logic [c_CLS_W-1:0]  in_class;
   logic [c_DIST_W-1:0] in_tk;
   logic                clear;
   logic                done;
   logic [1:0]          res_code;
   logic [c_NODE_W-1:0] res_node;
   logic [c_DIST_W-1:0] res_dist;
   logic [c_CLS_W-1:0]  rd_class;
   logic [c_NODE_W-1:0] rd_node;
   logic [c_VEC_W-1:0]  rd_w;
   logic                rd_used;

   modport master (
      output in_valid, in_x, in_class, in_tk, clear, rd_class, rd_node,
      input  in_ready, done, res_code, res_node, res_dist, rd_w, rd_used
   );

   modport slave (
      input  in_valid, in_x, in_class, in_tk, clear, rd_class, rd_node,
      output in_ready, done, res_code, res_node, res_dist, rd_w, rd_used
   );
endinterface
`default_nettype wire

// File: rtl/gam_learning_insert.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gam_learning_insert
// Purpose  : GAM learning stage. Scans the labelled class for the nearest node
//            (squared Euclidean), then pulls the winner toward the input or
//            inserts a new node. Owns the node store and exposes a
//            combinational read port for the recall stage.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module gam_learning_insert #(
   parameter int DIM         = 8,
   parameter int ELEM_W      = 8,
   parameter int CLASS_COUNT = 4,
   parameter int NODE_COUNT  = 16,
   parameter int UPD_SHIFT   = 2,
   parameter int CNT_W       = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   gam_learning_insert_if.slave bus
);
   localparam int c_CLS_W  = $clog2(CLASS_COUNT);
   localparam int c_NODE_W = $clog2(NODE_COUNT);
   localparam int c_DIST_W = 2*ELEM_W + $clog2(DIM);
   localparam int c_VEC_W  = DIM*ELEM_W;

   localparam logic [c_DIST_W-1:0] c_DIST_MAX  = '1;
   localparam logic [c_NODE_W-1:0] c_LAST_SLOT = c_NODE_W'(NODE_COUNT-1);
   localparam logic [1:0] c_RES_UPDATED  = 2'd0;
   localparam logic [1:0] c_RES_INSERTED = 2'd1;
   localparam logic [1:0] c_RES_FULL     = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DECIDE = 2'd2,
      ST_WRITE  = 2'd3
   } state_t;

   // Node store
   logic [c_VEC_W-1:0] r_w    [CLASS_COUNT][NODE_COUNT];
   logic               r_used [CLASS_COUNT][NODE_COUNT];
   logic [CNT_W-1:0]   r_cnt  [CLASS_COUNT][NODE_COUNT];

   // Request context and scan bookkeeping
   state_t              r_state;
   logic [c_VEC_W-1:0]  r_x;
   logic [c_CLS_W-1:0]  r_class;
   logic [c_DIST_W-1:0] r_tk;
   logic [c_NODE_W-1:0] r_slot;
   logic                r_issuing;
   logic                r_pend_valid;
   logic                r_pend_used;
   logic [c_NODE_W-1:0] r_pend_slot;
   logic [c_DIST_W-1:0] r_pend_dist;
   logic [c_DIST_W-1:0] r_min;
   logic [c_NODE_W-1:0] r_win;
   logic                r_any_used;
   logic                r_free_found;
   logic [c_NODE_W-1:0] r_free;
   logic [1:0]          r_code;
   logic [c_NODE_W-1:0] r_node;

   // Registered result outputs
   logic                r_done;
   logic [1:0]          r_res_code;
   logic [c_NODE_W-1:0] r_res_node;
   logic [c_DIST_W-1:0] r_res_dist;

   logic [c_VEC_W-1:0]    w_scan_w;
   logic                  w_scan_used;
   logic [c_VEC_W-1:0]    w_tgt_w;
   logic [c_VEC_W-1:0]    w_new_w;
   logic [2*ELEM_W-1:0]   w_sq [DIM];
   logic [c_DIST_W-1:0]   w_dist;
   logic                  w_ready;

   assign w_scan_w    = r_w[r_class][r_slot];
   assign w_scan_used = r_used[r_class][r_slot];
   assign w_tgt_w     = r_w[r_class][r_node];

   // clear has priority over a new request in IDLE
   assign w_ready = (r_state == ST_IDLE) && !bus.clear;

   // Per-element squared difference for the scanned slot and winner update step
   for (genvar gi = 0; gi < DIM; gi++) begin : g_elem
      logic [ELEM_W-1:0]        w_xe;
      logic [ELEM_W-1:0]        w_se;
      logic [ELEM_W-1:0]        w_te;
      logic [ELEM_W-1:0]        w_abs;
      logic [2*ELEM_W-1:0]      w_abs_x;
      logic signed [ELEM_W+1:0] w_te_s;
      logic signed [ELEM_W+1:0] w_diff;
      logic signed [ELEM_W+1:0] w_step;

      assign w_xe    = r_x[gi*ELEM_W +: ELEM_W];
      assign w_se    = w_scan_w[gi*ELEM_W +: ELEM_W];
      assign w_te    = w_tgt_w[gi*ELEM_W +: ELEM_W];
      assign w_abs   = (w_xe >= w_se) ? (w_xe - w_se) : (w_se - w_xe);
      assign w_abs_x = {{ELEM_W{1'b0}}, w_abs};
      assign w_sq[gi] = w_abs_x * w_abs_x;

      // Arithmetic shift floors toward -inf, so the result lies between W and x
      assign w_te_s = $signed({2'b00, w_te});
      assign w_diff = $signed({2'b00, w_xe}) - w_te_s;
      assign w_step = w_diff >>> UPD_SHIFT;
      assign w_new_w[gi*ELEM_W +: ELEM_W] = ELEM_W'(w_te_s + w_step);
   end

   // Exact distance sum; DIST_W has room for DIM maximal squares
   always_comb begin
      w_dist = '0;
      for (int i = 0; i < DIM; i++) begin
         w_dist = w_dist + {{(c_DIST_W-2*ELEM_W){1'b0}}, w_sq[i]};
      end
   end

   // Control FSM: accept, pipelined scan (distance registered, compared next cycle), decide, write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_x          <= '0;
         r_class      <= '0;
         r_tk         <= '0;
         r_slot       <= '0;
         r_issuing    <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_used  <= 1'b0;
         r_pend_slot  <= '0;
         r_pend_dist  <= '0;
         r_min        <= c_DIST_MAX;
         r_win        <= '0;
         r_any_used   <= 1'b0;
         r_free_found <= 1'b0;
         r_free       <= '0;
         r_code       <= '0;
         r_node       <= '0;
         r_done       <= 1'b0;
         r_res_code   <= '0;
         r_res_node   <= '0;
         r_res_dist   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid && w_ready) begin
                  r_x          <= bus.in_x;
                  r_class      <= bus.in_class;
                  r_tk         <= bus.in_tk;
                  r_slot       <= '0;
                  r_issuing    <= 1'b1;
                  r_pend_valid <= 1'b0;
                  r_min        <= c_DIST_MAX;
                  r_win        <= '0;
                  r_any_used   <= 1'b0;
                  r_free_found <= 1'b0;
                  r_free       <= '0;
                  r_state      <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_pend_valid <= r_issuing;
               r_pend_dist  <= w_dist;
               r_pend_used  <= w_scan_used;
               r_pend_slot  <= r_slot;
               if (r_issuing) begin
                  r_slot <= r_slot + 1'b1;
                  if (r_slot == c_LAST_SLOT) begin
                     r_issuing <= 1'b0;
                  end
               end
               // Ascending order plus strict compare keeps the lowest index on ties
               if (r_pend_valid) begin
                  if (r_pend_used) begin
                     r_any_used <= 1'b1;
                     if (r_pend_dist < r_min) begin
                        r_min <= r_pend_dist;
                        r_win <= r_pend_slot;
                     end
                  end else if (!r_free_found) begin
                     r_free_found <= 1'b1;
                     r_free       <= r_pend_slot;
                  end
               end
               if (!r_issuing && r_pend_valid) begin
                  r_state <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               if (!r_any_used || (r_min > r_tk)) begin
                  if (r_free_found) begin
                     r_code <= c_RES_INSERTED;
                     r_node <= r_free;
                  end else begin
                     r_code <= c_RES_FULL;
                     r_node <= r_win;
                  end
               end else begin
                  r_code <= c_RES_UPDATED;
                  r_node <= r_win;
               end
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               r_done     <= 1'b1;
               r_res_code <= r_code;
               r_res_node <= r_node;
               r_res_dist <= r_min;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Node store: IDLE clear wipes flags/counters, WRITE commits insert or update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CLASS_COUNT; c++) begin
            for (int n = 0; n < NODE_COUNT; n++) begin
               r_w[c][n]    <= '0;
               r_used[c][n] <= 1'b0;
               r_cnt[c][n]  <= '0;
            end
         end
      end else if ((r_state == ST_IDLE) && bus.clear) begin
         for (int c = 0; c < CLASS_COUNT; c++) begin
            for (int n = 0; n < NODE_COUNT; n++) begin
               r_used[c][n] <= 1'b0;
               r_cnt[c][n]  <= '0;
            end
         end
      end else if (r_state == ST_WRITE) begin
         if (r_code == c_RES_INSERTED) begin
            r_w[r_class][r_node]    <= r_x;
            r_used[r_class][r_node] <= 1'b1;
            r_cnt[r_class][r_node]  <= CNT_W'(1);
         end else begin
            r_w[r_class][r_node] <= w_new_w;
            if (r_cnt[r_class][r_node] != {CNT_W{1'b1}}) begin
               r_cnt[r_class][r_node] <= r_cnt[r_class][r_node] + 1'b1;
            end
         end
      end
   end

   assign bus.in_ready = w_ready;
   assign bus.done     = r_done;
   assign bus.res_code = r_res_code;
   assign bus.res_node = r_res_node;
   assign bus.res_dist = r_res_dist;
   assign bus.rd_w     = r_w[bus.rd_class][bus.rd_node];
   assign bus.rd_used  = r_used[bus.rd_class][bus.rd_node];

endmodule
`default_nettype wire
